// File: rtl/itag_pkg.sv
// Shared constants, FSM encoding and address-field helpers for the
// set-associative I-cache tag store.
package itag_pkg;

    localparam int NL   = 128;
    localparam int LSS  = 7;
    localparam int WAYS = 2;
    localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LSH  = LSS + 4;
    localparam int PSL  = LSH + 1;
    localparam int TS   = 1 + (32 - PSL);

    localparam int V_BIT  = TS - 1;
    localparam int TAG_HI = TS - 2;
    localparam int TAG_LO = 0;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } itag_st_e;

    // Set index sits just above the word/byte offset bits.
    function automatic logic [31:0] idx_of(input logic [31:0] addr, input int lss);
        return (addr >> 5) & ((32'd1 << lss) - 32'd1);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] addr, input int psl);
        return addr >> psl;
    endfunction

endpackage

// File: rtl/itag_way_ram.sv
// One way of tag storage: NL x TS, one synchronous read port and one write
// port; a read and a write to the same set in a cycle returns the old entry.
module itag_way_ram #(
    parameter int NL  = 128,
    parameter int LSS = 7,
    parameter int TS  = 21
) (
    input  logic           clk,
    input  logic           we,
    input  logic [LSS-1:0] waddr,
    input  logic [TS-1:0]  wdata,
    input  logic [LSS-1:0] raddr,
    output logic [TS-1:0]  rdata
);

    logic [TS-1:0] mem [NL];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/itag_assoc.sv
// N-way set-associative I-cache tag store: parallel tag compare, round-robin
// fill victim, single-line invalidate and a self-timed invalidate-all sweep.
module itag_assoc #(
    parameter int NL   = 128,
    parameter int LSS  = 7,
    parameter int WAYS = 2,
    parameter int WB   = (WAYS > 1) ? $clog2(WAYS) : 1,
    parameter int LSH  = LSS + 4,
    parameter int PSL  = LSH + 1,
    parameter int TS   = 1 + (32 - PSL)
) (
    input  logic          nGCLK,
    input  logic          rst,
    input  logic          lk_req,
    input  logic [31:0]   lk_addr,
    output logic          lk_valid,
    output logic          lk_hit,
    output logic [WB-1:0] lk_way,
    output logic [WB-1:0] lk_victim,
    input  logic          fill_req,
    input  logic [31:0]   fill_addr,
    input  logic          inv_req,
    input  logic [31:0]   inv_addr,
    input  logic [WB-1:0] inv_way,
    input  logic          inv_all,
    output logic          busy
);
    import itag_pkg::*;

    localparam int TAG_W  = 32 - PSL;
    localparam int E_VBIT = TS - 1;
    localparam int E_THI  = TS - 2;
    localparam int STAGES = 1;

    typedef struct packed {
        logic          valid;
        logic          hit;
        logic [WB-1:0] way;
    } lk_rsp_t;

    itag_st_e                  state, state_nxt;
    logic [LSS-1:0]            sweep_idx;
    logic [WB-1:0]             rr;
    logic [STAGES:1]           vld_pipe;
    logic [TAG_W-1:0]          lk_tag_q;
    logic                      idle, lk_acc, fill_go, inv_go;
    logic [WAYS-1:0]           way_we;
    logic [LSS-1:0]            wr_idx, rd_idx;
    logic [TS-1:0]             wr_data;
    logic [WAYS-1:0][TS-1:0]   way_rd;
    lk_rsp_t                   rsp;

    assign idle    = (state == IDLE) && !rst;
    assign lk_acc  = idle && lk_req;
    assign fill_go = idle && !inv_all && fill_req;
    assign inv_go  = idle && !inv_all && !fill_req && inv_req;
    assign rd_idx  = LSS'(idx_of(lk_addr, LSS));

    always_ff @(posedge nGCLK) begin
        if (rst)
            state <= SWEEP;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SWEEP:   if (sweep_idx == LSS'(NL - 1)) state_nxt = IDLE;
            IDLE:    if (inv_all) state_nxt = SWEEP;
            default: state_nxt = SWEEP;
        endcase
    end

    // Single shared write port image; only the selected ways are enabled.
    always_comb begin
        busy    = (state == SWEEP);
        way_we  = '0;
        wr_idx  = LSS'(idx_of(fill_addr, LSS));
        wr_data = '0;
        if (!rst) begin
            if (state == SWEEP) begin
                way_we = '1;
                wr_idx = sweep_idx;
            end else if (fill_go) begin
                way_we[rr] = 1'b1;
                wr_data    = {1'b1, TAG_W'(tag_of(fill_addr, PSL))};
            end else if (inv_go) begin
                way_we[inv_way] = 1'b1;
                wr_idx          = LSS'(idx_of(inv_addr, LSS));
            end
        end
    end

    always_ff @(posedge nGCLK) begin
        if (rst)
            sweep_idx <= '0;
        else if (state == SWEEP)
            sweep_idx <= sweep_idx + 1'b1;
        else if (inv_all)
            sweep_idx <= '0;
    end

    always_ff @(posedge nGCLK) begin
        if (rst)
            rr <= '0;
        else if (fill_go && WAYS > 1)
            rr <= rr + 1'b1;
    end

    // Shift in the accept bit; the cast drops the oldest stage.
    always_ff @(posedge nGCLK) begin
        if (rst)
            vld_pipe <= '0;
        else
            vld_pipe <= STAGES'({vld_pipe, lk_acc});
        lk_tag_q <= TAG_W'(tag_of(lk_addr, PSL));
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        itag_way_ram #(.NL(NL), .LSS(LSS), .TS(TS)) u_ram (
            .clk   (nGCLK),
            .we    (way_we[w]),
            .waddr (wr_idx),
            .wdata (wr_data),
            .raddr (rd_idx),
            .rdata (way_rd[w])
        );
    end

    // Scan high to low so the lowest matching way is the one left standing.
    always_comb begin
        rsp       = '0;
        rsp.valid = vld_pipe[STAGES];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (rsp.valid && way_rd[i][E_VBIT] && way_rd[i][E_THI:0] == lk_tag_q) begin
                rsp.hit = 1'b1;
                rsp.way = WB'(i);
            end
        end
    end

    assign lk_valid  = rsp.valid;
    assign lk_hit    = rsp.hit;
    assign lk_way    = rsp.way;
    assign lk_victim = rr;

endmodule
